// File: rtl/conv_mac_pkg.sv
// Shared defaults, accumulator type and saturating adders for conv_mac.
// The adders are only used when the block is built with SATURATE_EN.
package conv_mac_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int ACC_WIDTH_DEF = 32;
    localparam int ACC_MSB       = ACC_WIDTH_DEF - 1;

    typedef logic [ACC_WIDTH_DEF-1:0] acc_t;

    // Two's-complement add clamped to the most positive / most negative value.
    function automatic acc_t sat_add_s(acc_t a, acc_t b);
        acc_t s;
        s = a + b;
        if ((a[ACC_MSB] == b[ACC_MSB]) && (s[ACC_MSB] != a[ACC_MSB]))
            return a[ACC_MSB] ? {1'b1, {ACC_MSB{1'b0}}} : {1'b0, {ACC_MSB{1'b1}}};
        return s;
    endfunction

    function automatic acc_t sat_add_u(acc_t a, acc_t b);
        logic [ACC_WIDTH_DEF:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_WIDTH_DEF] ? '1 : s[ACC_MSB:0];
    endfunction

endpackage

// File: rtl/conv_mac_mul.sv
// Operand multiplier: WIDTH x WIDTH product extended to ACC_WIDTH.
// Combinational, no latency; no flow control.
module conv_mac_mul #(
    parameter int WIDTH      = 8,
    parameter int ACC_WIDTH  = 32,
    parameter bit SIGNED_MUL = 1'b1
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [ACC_WIDTH-1:0] prod_ext
);

    generate
        if (SIGNED_MUL) begin : g_signed
            logic signed [2*WIDTH-1:0] p;
            assign p        = $signed(a) * $signed(b);
            assign prod_ext = ACC_WIDTH'(p);
        end else begin : g_unsigned
            logic [2*WIDTH-1:0] p;
            assign p        = a * b;
            assign prod_ext = ACC_WIDTH'(p);
        end
    endgenerate

endmodule

// File: rtl/conv_mac.sv
// Streaming MAC over convolution windows; optional SATURATE_EN clamps each add.
// Latency: out_valid one cycle after the in_last beat; no backpressure, one beat per cycle.
// A window-start beat (in_first, or any beat while idle) discards any partial sum.
module conv_mac
    import conv_mac_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter bit SIGNED_MUL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 bias_valid,
    input  logic [ACC_WIDTH-1:0] bias_in,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_sum
);

    generate
        if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_width
            $error("conv_mac: ACC_WIDTH must be at least 2*WIDTH");
        end
`ifdef SATURATE_EN
        if (ACC_WIDTH != $bits(acc_t)) begin : g_bad_sat_width
            $error("conv_mac: saturating adders are sized for the package accumulator width");
        end
`endif
    endgenerate

    logic [ACC_WIDTH-1:0] acc;
    logic                 active;
    logic [ACC_WIDTH-1:0] prod;
    logic                 start;
    logic [ACC_WIDTH-1:0] add_lhs;
    logic [ACC_WIDTH-1:0] next_acc;

    conv_mac_mul #(
        .WIDTH      (WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED_MUL (SIGNED_MUL)
    ) u_mul (
        .a        (a_in),
        .b        (b_in),
        .prod_ext (prod)
    );

    assign start   = in_first || !active;
    assign add_lhs = start ? (bias_valid ? bias_in : '0) : acc;

`ifdef SATURATE_EN
    assign next_acc = SIGNED_MUL ? sat_add_s(add_lhs, prod) : sat_add_u(add_lhs, prod);
`else
    assign next_acc = add_lhs + prod;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            active    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                acc    <= next_acc;
                active <= !in_last;
                if (in_last) begin
                    out_valid <= 1'b1;
                    out_sum   <= next_acc;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mac.sv
// Scoreboard bench for conv_mac: one signed and one unsigned instance share stimulus.
// Build with +define+SATURATE_EN to exercise the clamping variant.
module tb_conv_mac;

    typedef struct {
        logic [31:0] sum;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, bias_valid = 1'b0;
    logic [7:0]  a_in = '0, b_in = '0;
    logic [31:0] bias_in = '0;
    logic        ov_s, ov_u;
    logic [31:0] os_s, os_u;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;

    exp_t        q[2][$];
    logic [31:0] last_exp[2];
    logic [31:0] m_acc[2];
    bit          m_act[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_mac #(.WIDTH(8), .ACC_WIDTH(32), .SIGNED_MUL(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a_in(a_in), .b_in(b_in), .bias_valid(bias_valid), .bias_in(bias_in),
        .out_valid(ov_s), .out_sum(os_s)
    );

    conv_mac #(.WIDTH(8), .ACC_WIDTH(32), .SIGNED_MUL(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .a_in(a_in), .b_in(b_in), .bias_valid(bias_valid), .bias_in(bias_in),
        .out_valid(ov_u), .out_sum(os_u)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] model_add(input logic [31:0] x, input logic [31:0] y, input bit sgn);
`ifdef SATURATE_EN
        longint s;
        if (sgn) begin
            s = longint'($signed(x)) + longint'($signed(y));
            if (s > 64'sd2147483647)  s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
        end else begin
            s = longint'({32'b0, x}) + longint'({32'b0, y});
            if (s > 64'sd4294967295) s = 64'sd4294967295;
        end
        return s[31:0];
`else
        if (sgn) return x + y;
        return x + y;
`endif
    endfunction

    function automatic logic [31:0] model_prod(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        longint p;
        if (sgn) p = longint'($signed(a)) * longint'($signed(b));
        else     p = longint'({56'b0, a}) * longint'({56'b0, b});
        return p[31:0];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_acc[d]    = '0;
            m_act[d]    = 1'b0;
            last_exp[d] = '0;
        end
    endtask

    // Drive one cycle of stimulus and advance the reference model.
    task automatic beat(input bit v, input bit f, input bit l, input logic [7:0] a,
                        input logic [7:0] b, input bit bv, input logic [31:0] bias);
        logic [31:0] lhs;
        exp_t        e;
        @(posedge clk);
        #1;
        in_valid = v; in_first = f; in_last = l;
        a_in = a; b_in = b; bias_valid = bv; bias_in = bias;
        if (v) begin
            for (int d = 0; d < 2; d++) begin
                lhs      = (f || !m_act[d]) ? (bv ? bias : 32'h0) : m_acc[d];
                m_acc[d] = model_add(lhs, model_prod(a, b, d == 0), d == 0);
                m_act[d] = !l;
                if (l) begin
                    e.sum = m_acc[d];
                    e.due = cyc + 1;
                    q[d].push_back(e);
                end
            end
        end
    endtask

    task automatic idle();
        beat(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), $urandom);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int d = 0; d < 2; d++) begin
                logic        v;
                logic [31:0] s;
                exp_t        e;
                v = (d == 0) ? ov_s : ov_u;
                s = (d == 0) ? os_s : os_u;
                if (v) begin
                    if (q[d].size() == 0) begin
                        check(d == 0 ? "spurious_out_s" : "spurious_out_u", 0, 1);
                    end else begin
                        e = q[d].pop_front();
                        check(d == 0 ? "sum_s" : "sum_u", s, e.sum);
                        check(d == 0 ? "latency_s" : "latency_u", cyc, e.due);
                        last_exp[d] = e.sum;
                    end
                end else begin
                    check(d == 0 ? "hold_s" : "hold_u", s, last_exp[d]);
                    if (q[d].size() != 0 && q[d][0].due < cyc) begin
                        e = q[d].pop_front();
                        check(d == 0 ? "missed_out_s" : "missed_out_u", cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin
        int budget;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid_s", ov_s, 0);
        check("reset_sum_s", os_s, 0);
        check("reset_valid_u", ov_u, 0);
        check("reset_sum_u", os_u, 0);
        mon_en = 1'b1;

        // 4-beat window, no bias: 70
        beat(1, 1, 0, 8'd1, 8'd5, 0, 0);
        beat(1, 0, 0, 8'd2, 8'd6, 0, 0);
        beat(1, 0, 0, 8'd3, 8'd7, 1, 32'd999);
        beat(1, 0, 1, 8'd4, 8'd8, 0, 0);
        // same with bias 100: 170
        beat(1, 1, 0, 8'd1, 8'd5, 1, 32'd100);
        beat(1, 0, 0, 8'd2, 8'd6, 0, 0);
        beat(1, 0, 0, 8'd3, 8'd7, 0, 0);
        beat(1, 0, 1, 8'd4, 8'd8, 0, 0);
        idle();
        // with bubbles: 170
        beat(1, 1, 0, 8'd1, 8'd5, 1, 32'd100);
        idle(); idle();
        beat(1, 0, 0, 8'd2, 8'd6, 0, 0);
        idle();
        beat(1, 0, 0, 8'd3, 8'd7, 0, 0);
        beat(1, 0, 1, 8'd4, 8'd8, 0, 0);
        idle(); idle();
        // one-beat window: signed FFFFFFF4, unsigned 1012
        beat(1, 1, 1, 8'hFD, 8'd4, 0, 0);
        idle();
        // back-to-back: 6 then 21
        beat(1, 1, 1, 8'd2, 8'd3, 0, 0);
        beat(1, 1, 0, 8'd4, 8'd5, 0, 0);
        beat(1, 0, 1, 8'd1, 8'd1, 0, 0);
        idle();
        // reset mid-window, then 49
        beat(1, 1, 0, 8'd9, 8'd9, 0, 0);
        beat(1, 0, 0, 8'd3, 8'd3, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        beat(1, 1, 1, 8'd7, 8'd7, 0, 0);
        idle();
        // overflow: wrap to 80003EF1 (7FFFFFFF when saturating signed)
        beat(1, 1, 1, 8'h7F, 8'h7F, 1, 32'h7FFFFFF0);
        idle();
        // negative saturation / unsigned overflow corner
        beat(1, 1, 1, 8'h80, 8'h7F, 1, 32'h80000010);
        beat(1, 1, 1, 8'hFF, 8'hFF, 1, 32'hFFFFFF00);
        idle();
        // mid-window restart discards partial sum
        beat(1, 1, 0, 8'd10, 8'd10, 0, 0);
        beat(1, 1, 0, 8'd2, 8'd2, 1, 32'd5);
        beat(1, 0, 1, 8'd1, 8'd3, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else beat(1, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                      8'($urandom), 8'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? 32'h7FFFFF00 + 32'($urandom_range(0, 255)) : $urandom);
        end

        budget = 20;
        while ((q[0].size() != 0 || q[1].size() != 0) && budget > 0) begin
            idle();
            budget--;
        end
        @(negedge clk);
        check("drain_s", q[0].size(), 0);
        check("drain_u", q[1].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_mac.md
Name: conv_mac

Overview:
- Streaming multiply-accumulate engine for convolution windows.
- Each valid beat multiplies `a_in` by `b_in` and adds the product to a running accumulator, which can be pre-loaded with a bias.
- The window is delimited by `in_first`/`in_last`; on the last beat the result is presented on `out_sum` with a one-cycle `out_valid` pulse.
- Sits between operand-fetch logic and the activation/writeback stage of the convolution datapath.

Parameters:
- WIDTH, 8: width of each operand `a_in`/`b_in`.
- ACC_WIDTH, 32: accumulator, bias and result width; must be >= 2*WIDTH.
- SIGNED_MUL, 1: 1 = operands are two's-complement signed; 0 = unsigned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_first  in  1  beat is the first of a window; qualified by `in_valid`.
- in_last  in  1  beat is the last of a window; qualified by `in_valid`.
- a_in  in  WIDTH  operand A (data).
- b_in  in  WIDTH  operand B (weight).
- bias_valid  in  1  apply `bias_in` to the window starting this beat.
- bias_in  in  ACC_WIDTH  bias value.
- out_valid  out  1  one-cycle pulse: `out_sum` holds a completed window.
- out_sum  out  ACC_WIDTH  completed window sum.

Behaviour:
- Reset (`rst`=1 at a clock edge):
  - `out_valid`=0, `out_sum`=0, accumulator=0, `active`=0.
  - Reset overrides all inputs in the same cycle.
- Product and extension:
  - `prod` = `a_in`*`b_in` at 2*WIDTH bits, signed or unsigned per SIGNED_MUL.
  - `prod` is extended to ACC_WIDTH: sign-extended if signed, zero-extended if unsigned.
- Accumulation: modulo 2^ACC_WIDTH (wrap-around), unless SATURATE_EN is defined.
- Beats with `in_valid`=0 are ignored; the accumulator holds. Bubbles are allowed anywhere inside a window.
- Beat with `in_valid`=1 and (`in_first`=1 or `active`=0):
  - acc <= base + `prod`, where base = `bias_in` if `bias_valid`=1, else 0.
  - `active` <= 1.
  - This beat restarts the window even if a window was open; the partial sum is discarded and there is no output for it.
- Beat with `in_valid`=1, `in_first`=0 and `active`=1: acc <= acc + `prod`.
- `bias_valid` is sampled only on window-starting beats; it is ignored elsewhere.
- Beat with `in_valid`=1 and `in_last`=1:
  - Next cycle: `out_valid`=1 and `out_sum` = final accumulator value, including this beat's product.
  - `active` <= 0.
- Latency: exactly 1 cycle from the `in_last` beat edge to `out_valid`.
- `in_first` and `in_last` together on one beat form a one-beat window: `out_sum` = base + `prod`.
- Back-to-back windows (a `last` beat followed immediately by a `first` beat) are fully supported with no dead cycle. Throughput is one beat per cycle and there is no backpressure.
- `out_valid` is high for exactly one cycle per window. `out_sum` holds its value until the next `out_valid`.
- `in_first`, `in_last` and `bias_valid` are don't-care when `in_valid`=0.

Optional Feature:
- Macro: SATURATE_EN.
- Defined: each add saturates instead of wrapping.
  - Signed: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Unsigned: clamp to [0, 2^ACC_WIDTH-1].
  - Bias + product on the start beat saturates the same way.
- Undefined: pure modulo-2^ACC_WIDTH wrap; no saturation logic is present.

Decomposition:
- Package `conv_mac_pkg`:
  - default WIDTH/ACC_WIDTH constants;
  - typedef `acc_t`, a logic vector of ACC_WIDTH;
  - function `sat_add` (signed and unsigned variants) used under SATURATE_EN.
- One sub-module, `conv_mac_mul`: WIDTH x WIDTH multiply plus extension to ACC_WIDTH, parameterised by SIGNED_MUL, purely combinational.
- The top level holds the accumulator, the `active` flag and output registers.

Test Plan:
- Window of 4 beats, A={1,2,3,4}, B={5,6,7,8}, no bias -> one `out_valid` pulse 1 cycle after the last beat, `out_sum`=70.
- Same window with `bias_valid`=1, `bias_in`=100 on the first beat -> `out_sum`=170; idle bubbles inserted between beats give the same 170.
- Signed: one-beat window (first=last=1), A=8'hFD (-3), B=4 -> `out_sum`=32'hFFFFFFF4. With SIGNED_MUL=0 the same inputs give 253*4=1012.
- Back-to-back windows {2*3} then {4*5, 1*1}, no gap -> `out_sum`=6, then 21, with two distinct `out_valid` pulses.
- `rst` asserted mid-window after 2 beats, then a fresh window {7*7} -> no output for the aborted window, then `out_sum`=49.
- Overflow: `bias_in`=32'h7FFFFFF0, A=B=8'h7F (16129) -> wrap to 32'h80003EF1. With SATURATE_EN defined -> 32'h7FFFFFFF.
